// File: rtl/if_prefetch_if.sv
// Instruction-bus link between the prefetch unit (master) and instruction memory (slave).
// Pipelined word reads: req/gnt handshake on the request side, in-order rvalid responses.
interface if_prefetch_if;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (
    output req,
    output addr,
    input  gnt,
    input  rvalid,
    input  rdata
  );

  modport slave (
    input  req,
    input  addr,
    output gnt,
    output rvalid,
    output rdata
  );
endinterface

// File: rtl/if_prefetch.sv
// Instruction-fetch prefetch unit: up to two pipelined reads in flight, DEPTH-entry FIFO
// of {instruction, address}, one instruction per cycle to decode, flush/refetch on jump.
module if_prefetch #(
  parameter int unsigned DEPTH      = 4,
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          jump_flag_i,
  input  logic [31:0]   jump_addr_i,
  input  logic          hold_flag_i,
  if_prefetch_if.master ibus,
  output logic          inst_valid_o,
  output logic [31:0]   inst_o,
  output logic [31:0]   inst_addr_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned SW = CW + 2;
  localparam logic [31:0] INST_NOP = 32'h0000_0001;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   deliver_pc_q, deliver_pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [1:0]    outst_q, outst_d;
  logic [1:0]    discard_q, discard_d;

  logic [31:0]   ent_data [DEPTH];
  logic [31:0]   ent_addr [DEPTH];

  logic          grant;
  logic          resp;
  logic          drop;
  logic          push;
  logic          pop;
  logic [SW-1:0] committed;

  // Space is reserved for every in-flight response that will be kept, so a push never
  // lands in a full FIFO.
  always_comb begin
    committed = SW'(count_q) + SW'(outst_q) - SW'(discard_q);
    ibus.req  = !rst && !jump_flag_i && (outst_q < 2'd2) && (committed < SW'(DEPTH));
  end

  assign ibus.addr = fetch_pc_q;

  assign grant = ibus.req && ibus.gnt;
  assign resp  = ibus.rvalid;
  assign drop  = resp && ((discard_q != 2'd0) || jump_flag_i);
  assign push  = resp && !drop;
  assign pop   = inst_valid_o && !hold_flag_i && !jump_flag_i;

  always_comb begin
    fetch_pc_d   = fetch_pc_q;
    deliver_pc_d = deliver_pc_q;
    resp_pc_d    = resp_pc_q;
    count_d      = count_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    outst_d      = outst_q;
    discard_d    = discard_q;

    if (jump_flag_i) begin
      // Everything still in flight after this cycle's response belongs to the old stream.
      fetch_pc_d   = jump_addr_i;
      deliver_pc_d = jump_addr_i;
      resp_pc_d    = jump_addr_i;
      count_d      = '0;
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      outst_d      = outst_q - {1'b0, resp};
      discard_d    = outst_q - {1'b0, resp};
    end else begin
      if (grant) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      outst_d = outst_q + {1'b0, grant} - {1'b0, resp};
      if (resp && (discard_q != 2'd0)) begin
        discard_d = discard_q - 2'd1;
      end
      if (push) begin
        wr_ptr_d  = wr_ptr_q + PW'(1);
        resp_pc_d = resp_pc_q + 32'd4;
      end
      if (pop) begin
        rd_ptr_d     = rd_ptr_q + PW'(1);
        deliver_pc_d = inst_addr_o + 32'd4;
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q   <= RESET_ADDR;
      deliver_pc_q <= RESET_ADDR;
      resp_pc_q    <= RESET_ADDR;
      count_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      outst_q      <= '0;
      discard_q    <= '0;
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      deliver_pc_q <= deliver_pc_d;
      resp_pc_q    <= resp_pc_d;
      count_q      <= count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      outst_q      <= outst_d;
      discard_q    <= discard_d;
    end
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [31:0] data_q;
      logic [31:0] addr_q;

      always_ff @(posedge clk) begin
        if (push && (wr_ptr_q == PW'(gi))) begin
          data_q <= ibus.rdata;
          addr_q <= resp_pc_q;
        end
      end

      assign ent_data[gi] = data_q;
      assign ent_addr[gi] = addr_q;
    end
  endgenerate

  assign inst_valid_o = (count_q != '0);
  assign inst_o       = inst_valid_o ? ent_data[rd_ptr_q] : INST_NOP;
  assign inst_addr_o  = inst_valid_o ? ent_addr[rd_ptr_q] : deliver_pc_q;

  // Bookkeeping invariants; ignored by synthesis.
  a_discard_le_outst : assert property (@(posedge clk) disable iff (rst)
    discard_q <= outst_q);
  a_outst_max : assert property (@(posedge clk) disable iff (rst)
    outst_q <= 2'd2);
  a_resp_expected : assert property (@(posedge clk) disable iff (rst)
    resp |-> (outst_q != 2'd0));
  a_no_overflow : assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && (count_q == CW'(DEPTH))));

endmodule

// File: tb/tb_if_prefetch.sv
// Bench for if_prefetch: latency-programmable in-order memory model, scoreboard of the
// expected delivered stream, and directed reset/hold/jump/wrap scenarios.
module tb_if_prefetch;
  localparam logic [31:0] RESET_ADDR = 32'hFFFF_FFF8;
  localparam logic [31:0] NOP        = 32'h0000_0001;

  logic        clk        = 1'b0;
  logic        rst        = 1'b1;
  logic        jump_flag  = 1'b0;
  logic [31:0] jump_addr  = 32'h0;
  logic        hold_flag  = 1'b0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_addr;

  logic        mem_gnt    = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata  = 32'h0;

  if_prefetch_if ibus ();
  assign ibus.gnt    = mem_gnt;
  assign ibus.rvalid = mem_rvalid;
  assign ibus.rdata  = mem_rdata;

  always #5 clk = ~clk;

  if_prefetch #(.DEPTH(4), .RESET_ADDR(RESET_ADDR)) dut (
    .clk          (clk),
    .rst          (rst),
    .jump_flag_i  (jump_flag),
    .jump_addr_i  (jump_addr),
    .hold_flag_i  (hold_flag),
    .ibus         (ibus),
    .inst_valid_o (inst_valid),
    .inst_o       (inst),
    .inst_addr_o  (inst_addr)
  );

  int total = 0;
  int bad   = 0;
  int n_pop = 0;
  int cyc   = 0;
  int lat   = 1;
  bit gnt_rand = 1'b0;

  logic [31:0] exp_q [$];
  logic [31:0] pend_addr [$];
  int          pend_due [$];
  logic        prev_stall = 1'b0;
  logic [31:0] prev_addr  = 32'h0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %b required %b", name, act, req);
    end
  endtask

  task automatic sb_restart(input logic [31:0] a);
    exp_q.delete();
    for (int i = 0; i < 256; i++) exp_q.push_back(a + 32'(4 * i));
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Memory driver: grant policy and in-order responses once their due cycle is reached.
  always @(posedge clk) begin
    cyc++;
    #1;
    mem_gnt = gnt_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
    if (pend_addr.size() != 0 && pend_due[0] <= cyc) begin
      mem_rvalid = 1'b1;
      mem_rdata  = mem_word(pend_addr[0]);
    end else begin
      mem_rvalid = 1'b0;
      mem_rdata  = 32'hDEAD_BEEF;
    end
  end

  // Memory bookkeeping, sampled mid-cycle when all inputs are settled.
  always @(negedge clk) begin
    if (rst) begin
      pend_addr.delete();
      pend_due.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && !jump_flag) begin
        chk1("stall_req", ibus.req, 1'b1);
        chk("stall_addr", ibus.addr, prev_addr);
      end
      prev_stall = ibus.req && !ibus.gnt;
      prev_addr  = ibus.addr;
      if (ibus.rvalid && pend_addr.size() != 0) begin
        void'(pend_addr.pop_front());
        void'(pend_due.pop_front());
      end
      if (ibus.req && ibus.gnt) begin
        pend_addr.push_back(ibus.addr);
        pend_due.push_back(cyc + lat);
      end
    end
  end

  // Scoreboard monitor: every consumed instruction must be the next expected one.
  always @(negedge clk) begin
    logic [31:0] e;
    if (!rst && inst_valid && !hold_flag && !jump_flag) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_underflow: got addr %h required no delivery", inst_addr);
      end else begin
        e = exp_q.pop_front();
        chk("sb_addr", inst_addr, e);
        chk("sb_inst", inst, mem_word(e));
        $display("deliver cyc=%0d addr=%h inst=%h", cyc, inst_addr, inst);
        n_pop++;
      end
    end
  end

  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog: got timeout required finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int p0;
    int exp_disc;
    logic [31:0] h_addr;
    logic [31:0] h_inst;

    // Reset state and first-fetch latency, streaming across the 2^32 wrap.
    tick();
    tick();
    chk1("rst_valid", inst_valid, 1'b0);
    chk("rst_inst", inst, NOP);
    chk("rst_addr", inst_addr, RESET_ADDR);
    chk1("rst_req", ibus.req, 1'b0);
    rst = 1'b0;
    sb_restart(RESET_ADDR);
    #1;
    chk1("first_req", ibus.req, 1'b1);
    chk("first_addr", ibus.addr, RESET_ADDR);
    tick();
    chk1("lat_n1_valid", inst_valid, 1'b0);
    tick();
    chk1("lat_n2_valid", inst_valid, 1'b1);
    chk("wrap_a0", inst_addr, 32'hFFFF_FFF8);
    tick();
    chk("wrap_a1", inst_addr, 32'hFFFF_FFFC);
    tick();
    chk("wrap_a2", inst_addr, 32'h0000_0000);
    tick();
    chk("wrap_a3", inst_addr, 32'h0000_0004);

    // Streaming with irregular grants.
    p0 = n_pop;
    gnt_rand = 1'b1;
    repeat (30) tick();
    chk1("stream_progress", (n_pop - p0) >= 10, 1'b1);
    gnt_rand = 1'b0;
    repeat (4) tick();

    // Hold: outputs frozen, FIFO fills to DEPTH, request drops; release pops back-to-back.
    chk1("hold_pre_valid", inst_valid, 1'b1);
    h_addr = inst_addr;
    h_inst = inst;
    hold_flag = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold_addr", inst_addr, h_addr);
      chk("hold_inst", inst, h_inst);
    end
    chk("hold_count", 32'(dut.count_q), 32'd4);
    chk1("hold_req", ibus.req, 1'b0);
    hold_flag = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk1("release_valid", inst_valid, 1'b1);
      tick();
    end

    // Jump with two slow responses in flight: both must be discarded.
    lat = 3;
    k = 0;
    while (!(pend_addr.size() == 2 && !ibus.rvalid) && k < 50) begin
      tick();
      k++;
    end
    chk1("wait_two_outst", k < 50, 1'b1);
    exp_disc = pend_addr.size() - (ibus.rvalid ? 1 : 0);
    jump_addr = 32'h0000_0100;
    jump_flag = 1'b1;
    sb_restart(32'h0000_0100);
    #1;
    chk1("jump_req_off", ibus.req, 1'b0);
    tick();
    jump_flag = 1'b0;
    #1;
    chk1("j1_valid", inst_valid, 1'b0);
    chk("j1_inst", inst, NOP);
    chk("j1_addr", inst_addr, 32'h0000_0100);
    chk("j1_discard", 32'(dut.discard_q), 32'(exp_disc));
    chk1("j1_req_blocked", ibus.req, 1'b0);
    k = 0;
    while (!inst_valid && k < 50) begin
      tick();
      k++;
    end
    chk1("j1_wait_valid", k < 50, 1'b1);
    chk("j1_first_addr", inst_addr, 32'h0000_0100);

    // Jump coinciding with a response and a would-be pop.
    lat = 2;
    k = 0;
    while (!(ibus.rvalid && inst_valid) && k < 50) begin
      tick();
      k++;
    end
    chk1("wait_resp_pop", k < 50, 1'b1);
    exp_disc = pend_addr.size() - 1;
    jump_addr = 32'h0000_2000;
    jump_flag = 1'b1;
    sb_restart(32'h0000_2000);
    tick();
    jump_flag = 1'b0;
    #1;
    chk1("j2_valid", inst_valid, 1'b0);
    chk("j2_addr", inst_addr, 32'h0000_2000);
    chk("j2_discard", 32'(dut.discard_q), 32'(exp_disc));
    k = 0;
    while (!inst_valid && k < 50) begin
      tick();
      k++;
    end
    chk1("j2_wait_valid", k < 50, 1'b1);
    chk("j2_first_addr", inst_addr, 32'h0000_2000);

    // Zero-wait memory: target valid exactly three cycles after the jump.
    lat = 1;
    repeat (6) tick();
    k = 0;
    while (!(ibus.rvalid && inst_valid && pend_addr.size() == 1) && k < 50) begin
      tick();
      k++;
    end
    chk1("wait_steady", k < 50, 1'b1);
    jump_addr = 32'h0000_0300;
    jump_flag = 1'b1;
    sb_restart(32'h0000_0300);
    tick();
    jump_flag = 1'b0;
    #1;
    chk1("j3_p1_valid", inst_valid, 1'b0);
    chk1("j3_p1_req", ibus.req, 1'b1);
    chk("j3_p1_reqaddr", ibus.addr, 32'h0000_0300);
    tick();
    chk1("j3_p2_valid", inst_valid, 1'b0);
    tick();
    chk1("j3_p3_valid", inst_valid, 1'b1);
    chk("j3_p3_addr", inst_addr, 32'h0000_0300);

    // Reset with two requests in flight and a partly filled FIFO.
    hold_flag = 1'b1;
    lat = 3;
    k = 0;
    while (!(pend_addr.size() == 2 && dut.count_q != 0) && k < 50) begin
      tick();
      k++;
    end
    chk1("wait_mid_rst", k < 50, 1'b1);
    rst = 1'b1;
    #1;
    chk1("mrst_req_off", ibus.req, 1'b0);
    tick();
    rst = 1'b0;
    hold_flag = 1'b0;
    lat = 1;
    sb_restart(RESET_ADDR);
    #1;
    chk("mrst_count", 32'(dut.count_q), 32'd0);
    chk("mrst_outst", 32'(dut.outst_q), 32'd0);
    chk("mrst_discard", 32'(dut.discard_q), 32'd0);
    chk1("mrst_valid", inst_valid, 1'b0);
    chk("mrst_inst", inst, NOP);
    chk("mrst_addr", inst_addr, RESET_ADDR);
    chk1("mrst_req", ibus.req, 1'b1);
    chk("mrst_reqaddr", ibus.addr, RESET_ADDR);
    p0 = n_pop;
    repeat (10) tick();
    chk1("mrst_progress", (n_pop - p0) >= 5, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_prefetch.md
# if_prefetch

Instruction-fetch prefetch unit in front of the `if_id` register and decode. It issues pipelined word reads on the instruction bus, with up to two requests in flight, and buffers returned words in a DEPTH-entry FIFO. It presents one instruction per cycle, with its address, to the decode path. On a taken jump from `ex`, it flushes the buffer, discards stale in-flight responses and refetches from the jump target.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `RESET_ADDR`, 32'h0000_0000: first fetch address after reset.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: reset. **One clock; reset is synchronous and active-high.**
- `jump_flag_i` in 1: taken jump/branch/trap from `ex`.
- `jump_addr_i` in 32: jump target; word aligned.
- `hold_flag_i` in 1: stall from ctrl; when high, the head instruction is not consumed.
- `ibus_req_o` out 1: read request.
- `ibus_addr_o` out 32: request address.
- `ibus_gnt_i` in 1: request accepted this cycle (`req && gnt` = handshake).
- `ibus_rvalid_i` in 1: read data valid. Responses return in order, ≥1 cycle after grant.
- `ibus_rdata_i` in 32: read data.
- `inst_valid_o` out 1: FIFO head holds a valid instruction.
- `inst_o` out 32: head instruction; 32'h0000_0001 (INST_NOP) when not valid.
- `inst_addr_o` out 32: address of the head instruction, or of the next expected instruction when empty.

## Operation
- State:
  - `fetch_pc`: next request address.
  - `deliver_pc`: next delivered address.
  - FIFO `count`, 0..DEPTH.
  - `outst`: in-flight requests, 0..2.
  - `discard`: stale responses still to drop, 0..2, always ≤ `outst`.
- Request:
  - `ibus_req_o = !rst && !jump_flag_i && outst<2 && (count + outst - discard) < DEPTH`.
  - `ibus_addr_o = fetch_pc`.
  - Combinational, so no grant can occur in a jump cycle.
- Grant (`req && gnt`): `fetch_pc += 4`; `outst += 1`.
- Response (`rvalid`): `outst -= 1`.
  - If `discard>0`: `discard -= 1` and the data is dropped.
  - Else: write {data, addr} into the FIFO.
  - Simultaneous grant and response leaves `outst` unchanged.
- Pop: when `inst_valid_o && !hold_flag_i && !jump_flag_i`.
  - `count -= 1`, read pointer advances, `deliver_pc = inst_addr_o + 4`.
  - Simultaneous push and pop leaves `count` unchanged.
  - Push into a full FIFO cannot occur, because the request rule reserves space.
- Jump (highest priority):
  - FIFO emptied (`count=0`, pointers reset).
  - `fetch_pc = deliver_pc = jump_addr_i`.
  - `discard` = in-flight count after this cycle's response, i.e. `outst - rvalid`. A response arriving in the jump cycle is dropped.
  - Pop ignored.
- Outputs:
  - `inst_valid_o = count!=0`.
  - `inst_o` = head data when valid, else NOP.
  - `inst_addr_o` = head addr when valid, else `deliver_pc`.
- Address arithmetic: 32-bit, wraps modulo 2^32 (32'hFFFF_FFFC + 4 = 0).
- Reset values:
  - `fetch_pc = deliver_pc = RESET_ADDR`; `count = outst = discard = 0`.
  - Outputs: `ibus_req_o=0`, `inst_valid_o=0`, `inst_o=NOP`, `inst_addr_o=RESET_ADDR`.
  - Reset mid-transaction drops all in-flight state. The bus is reset in the same cycle, so no late responses are expected.

## Timing
- First request: `ibus_req_o=1` in the first cycle after `rst` deasserts.
- Fetch latency: grant at cycle N, zero-wait `rvalid` at N+1, `inst_valid_o` at N+2. There is no bypass from the bus to the output.
- Sustained throughput: 1 instruction/cycle when the bus grants every cycle and returns data 1 cycle later (`outst` stays at 1).
- Jump at cycle J: `inst_valid_o=0` at J+1. The request for the target is issued at J+1 if `outst<2` after J; otherwise at the first cycle a slot frees. With zero-wait memory, the first target instruction is valid at J+3.
- `hold_flag_i`: outputs stay stable while held. Fetching continues until `count + outst - discard = DEPTH`.
- Ungranted request: address and request stay stable until grant, unless a jump occurs. A jump deasserts the request for one cycle and then re-presents it at the new address.

## Test plan
- Reset, then zero-wait memory with mem[a]=a, no hold → `inst_addr_o`/`inst_o` = 0x0, 0x4, 0x8… on consecutive cycles starting 2 cycles after the first grant.
- Hold high for 10 cycles with `DEPTH=4` → `count` saturates at 4 and `ibus_req_o=0`. On release, 4 back-to-back pops, then streaming resumes with no lost or duplicated address.
- Two requests outstanding with `rvalid` delayed 3 cycles; jump to 0x100 → both stale responses are dropped; the first valid instruction has `inst_addr_o=0x100`.
- Jump in the same cycle as an `rvalid` and a pop → response dropped, pop ignored, `discard` equals the remaining `outst`, next valid address is the target.
- `RESET_ADDR=32'hFFFF_FFF8`, streaming → addresses FFFF_FFF8, FFFF_FFFC, 0000_0000.
- `rst` asserted with 2 requests outstanding and FIFO at 3 → the next cycle shows all outputs at reset values and `count=outst=discard=0`.
